img_rsz_blk_sched: RTL and testbench
====================================

Name: img_rsz_blk_sched

Overview:
- Fair scheduler between the block buffer's "block is enough" map and the Compute stage.
- Replaces fixed find-first-set priority with raster-order round-robin, so low-index blocks cannot starve others.
- Holds a registered, stable valid/ready offer to Compute.
- Limits in-flight blocks with a credit counter returned by Compute on completion.

Parameters:
BLK_X_NUM, RSZ_IMG_WIDTH_SIZE, number of block columns
BLK_Y_NUM, RSZ_IMG_HEIGHT_SIZE, number of block rows
MAX_OUTSTANDING, RSZ_BLK_MAX_OUTSTANDING (2), max blocks handed to Compute and not yet done

Ports:
Clk  input  1  clock
Reset  input  1  asynchronous, active-high reset
BlkIsEnough  input  [BLK_X_NUM-1:0] x [BLK_Y_NUM-1:0]  per-block ready map from block buffer
FrameFlush  input  1  restart round-robin at block (0,0)
CompBlkXMsk  output  BLK_X_NUM  one-hot column of granted block, valid while CompBlkEn
CompBlkYMsk  output  BLK_Y_NUM  one-hot row of granted block, valid while CompBlkEn
CompBlkEn  output  1  clear pulse to block buffer counter (= handshake)
CompBlkXIdx  output  $clog2(BLK_X_NUM)  offered block column
CompBlkYIdx  output  $clog2(BLK_Y_NUM)  offered block row
CompBlkVld  output  1  offer valid
CompBlkRdy  input  1  Compute accepts
CompBlkDone  input  1  Compute finished one block (returns one credit)

Behaviour:
- Reset values:
  - CompBlkVld=0; XIdx=YIdx=0; masks=0; CompBlkEn=0.
  - Last-grant pointer=(BLK_Y_NUM-1, BLK_X_NUM-1), so the first search starts at (0,0).
  - Credits=MAX_OUTSTANDING; state=IDLE.
- Credit counter:
  - Width $clog2(MAX_OUTSTANDING+1).
  - Decrements on handshake (Vld&Rdy) and increments on CompBlkDone.
  - Both in the same cycle: unchanged.
  - Done at Credits=MAX_OUTSTANDING is ignored (saturate; assertion in sim).
  - Handshake only occurs with Credits>0.
- Candidate search (combinational):
  - Raster order is row-major, index = y*BLK_X_NUM+x.
  - First set bit of BlkIsEnough strictly after the pointer, wrapping.
  - The pointer block itself is searched last.
  - The currently offered block is masked out of the search.
- States:
  - IDLE: Vld=0. If a candidate exists and Credits>0, load XIdx/YIdx at the next edge and go to OFFER. Latency is one cycle from BlkIsEnough rising to Vld.
  - OFFER: Vld=1. XIdx/YIdx are stable and Vld does not drop until handshake.
  - OFFER with handshake:
    - CompBlkEn=1 in the same cycle; masks = one-hot of the held indices; otherwise masks=0.
    - Pointer <= held block.
    - If another candidate exists (offered block excluded) and post-handshake credits >0, load it and stay in OFFER. This allows back-to-back offers with no bubble.
    - Otherwise go to IDLE.
- Block buffer clears the granted block's BlkIsEnough on the CompBlkEn edge. Because the offered block is excluded from the search, it is never re-offered on stale data.
- BlkIsEnough of the offered block dropping while in OFFER (not expected) does not withdraw the offer.
- FrameFlush:
  - Sets pointer to (BLK_Y_NUM-1, BLK_X_NUM-1) and Credits to MAX_OUTSTANDING at the next edge.
  - Does not affect a held offer.
  - Simultaneous with a handshake: flush wins for the pointer, and the handshake still consumes a credit (Credits=MAX-1).
- Reset mid-offer: Vld drops immediately (async). Compute must treat it as a frame abort.

Decomposition:
- ImgRszPkg:
  - RSZ_BLK_MAX_OUTSTANDING.
  - Typedef enum logic {BLK_SCHED_IDLE, BLK_SCHED_OFFER} blk_sched_st_t.
  - Existing RSZ_IMG_*_SIZE/IDX_W constants.
- Sub-module img_rsz_rr_pick_2d: combinational rotating-priority finder.
  - Inputs: request map, pointer, exclude mask.
  - Outputs: found, X/Y index.
  - Reused for other shared resources.
- One-hot masks come from the existing one-hot decode on the held indices.

Test Plan:
- Round-robin order (4x4 map, Credits ample): set (0,0),(0,3),(2,1) simultaneously with Rdy=1 -> grants in order (0,0),(0,3),(2,1). CompBlkEn pulses once each with matching one-hot masks. Vld is first seen 1 cycle after map set.
- Starvation check: keep (0,0) re-asserting every cycle after its clear, with (3,3) set -> (3,3) is granted directly after the first (0,0) grant, before (0,0) again.
- Backpressure: Vld=1 for (1,2) with Rdy=0 for 10 cycles while (0,1) is also set -> Idx held at (1,2), no CompBlkEn, Vld never drops. Rdy=1 -> (1,2) handshake, then (0,1) offered the next cycle.
- Credits (MAX=2): 3 blocks set, no Done -> exactly 2 handshakes, then Vld=0. Pulse Done -> third block offered 1 cycle later. Done+handshake in the same cycle -> credit count unchanged.
- FrameFlush: pointer at (2,2), map has (1,0) and (3,0), pulse FrameFlush -> next grant is (1,0), not (3,0). Credits restored to 2.
- Async reset while Vld=1 -> Vld, Idx and masks go to 0 without a clock edge. After release, the first grant searches from (0,0).

Source files
------------

// File: rtl/img_rsz_blk_sched_pkg.sv
// Shared constants and types for the resize block scheduler.
//   RSZ_IMG_WIDTH_SIZE / RSZ_IMG_HEIGHT_SIZE : block grid columns / rows
//   RSZ_IMG_X_IDX_W / RSZ_IMG_Y_IDX_W        : index widths for the grid
//   RSZ_BLK_MAX_OUTSTANDING                  : blocks in flight to Compute
//   blk_sched_st_t                           : scheduler FSM states
package img_rsz_blk_sched_pkg;

  localparam int unsigned RSZ_IMG_WIDTH_SIZE      = 4;
  localparam int unsigned RSZ_IMG_HEIGHT_SIZE     = 4;
  localparam int unsigned RSZ_IMG_X_IDX_W         = $clog2(RSZ_IMG_WIDTH_SIZE);
  localparam int unsigned RSZ_IMG_Y_IDX_W         = $clog2(RSZ_IMG_HEIGHT_SIZE);
  localparam int unsigned RSZ_BLK_MAX_OUTSTANDING = 2;

  typedef enum logic {
    BLK_SCHED_IDLE,
    BLK_SCHED_OFFER
  } blk_sched_st_t;

endpackage

// File: rtl/img_rsz_rr_pick_2d.sv
// Combinational rotating-priority finder over a 2-D request map.
// Scans raster order (index = y*X_NUM + x) starting strictly after the
// pointer and wrapping, so the pointer cell itself is checked last.
//   i_req    : request map [y][x]
//   i_excl   : cells removed from the search [y][x]
//   i_ptr_x/y: last-granted cell
//   o_found  : a request was found
//   o_x_idx/o_y_idx : winning cell (0 when nothing found)
module img_rsz_rr_pick_2d #(
  parameter int unsigned X_NUM = 4,
  parameter int unsigned Y_NUM = 4
) (
  input  logic [Y_NUM-1:0][X_NUM-1:0] i_req,
  input  logic [Y_NUM-1:0][X_NUM-1:0] i_excl,
  input  logic [$clog2(X_NUM)-1:0]    i_ptr_x,
  input  logic [$clog2(Y_NUM)-1:0]    i_ptr_y,
  output logic                        o_found,
  output logic [$clog2(X_NUM)-1:0]    o_x_idx,
  output logic [$clog2(Y_NUM)-1:0]    o_y_idx
);

  localparam int unsigned N  = X_NUM * Y_NUM;
  localparam int unsigned XW = $clog2(X_NUM);
  localparam int unsigned YW = $clog2(Y_NUM);

  int unsigned v_ptr;
  int unsigned v_idx;
  int unsigned v_dist;
  int unsigned v_best;

  // Distance from the pointer in raster order: 1..N, pointer itself = N.
  // The smallest distance among eligible requests wins.
  always_comb begin
    o_found = 1'b0;
    o_x_idx = '0;
    o_y_idx = '0;
    v_ptr   = 32'(i_ptr_y) * X_NUM + 32'(i_ptr_x);
    v_idx   = 0;
    v_dist  = 0;
    v_best  = N + 1;
    for (int unsigned y = 0; y < Y_NUM; y++) begin
      for (int unsigned x = 0; x < X_NUM; x++) begin
        v_idx = y * X_NUM + x;
        if (i_req[y][x] && !i_excl[y][x]) begin
          v_dist = (v_idx > v_ptr) ? (v_idx - v_ptr) : (v_idx + N - v_ptr);
          if (v_dist < v_best) begin
            v_best  = v_dist;
            o_found = 1'b1;
            o_x_idx = XW'(x);
            o_y_idx = YW'(y);
          end
        end
      end
    end
  end

endmodule

// File: rtl/img_rsz_blk_sched.sv
// Fair raster-order round-robin scheduler between the block buffer's
// "block is enough" map and the Compute stage, with credit-limited issue.
//   Clk, Reset           : clock, async active-high reset
//   BlkIsEnough[y][x]    : per-block ready map from the block buffer
//   FrameFlush           : restart round-robin at (0,0), restore credits
//   CompBlkXIdx/YIdx     : offered block, stable while CompBlkVld
//   CompBlkVld/CompBlkRdy: offer handshake to Compute
//   CompBlkEn            : handshake pulse, clears the block buffer counter
//   CompBlkXMsk/YMsk     : one-hot of the granted block while CompBlkEn
//   CompBlkDone          : Compute finished one block, returns a credit
module img_rsz_blk_sched
  import img_rsz_blk_sched_pkg::*;
#(
  parameter int unsigned BLK_X_NUM       = RSZ_IMG_WIDTH_SIZE,
  parameter int unsigned BLK_Y_NUM       = RSZ_IMG_HEIGHT_SIZE,
  parameter int unsigned MAX_OUTSTANDING = RSZ_BLK_MAX_OUTSTANDING
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0] BlkIsEnough,
  input  logic                                FrameFlush,
  output logic [BLK_X_NUM-1:0]                CompBlkXMsk,
  output logic [BLK_Y_NUM-1:0]                CompBlkYMsk,
  output logic                                CompBlkEn,
  output logic [$clog2(BLK_X_NUM)-1:0]        CompBlkXIdx,
  output logic [$clog2(BLK_Y_NUM)-1:0]        CompBlkYIdx,
  output logic                                CompBlkVld,
  input  logic                                CompBlkRdy,
  input  logic                                CompBlkDone
);

  localparam int unsigned XW = $clog2(BLK_X_NUM);
  localparam int unsigned YW = $clog2(BLK_Y_NUM);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);

  blk_sched_st_t r_state, w_state_nxt;

  logic [XW-1:0] r_x_idx, r_ptr_x, w_sp_x, w_pick_x;
  logic [YW-1:0] r_y_idx, r_ptr_y, w_sp_y, w_pick_y;
  logic [CW-1:0] r_cred, w_cred_base, w_cred_nxt;
  logic          w_offer, w_hs, w_found, w_load;
  logic [BLK_X_NUM-1:0] w_x_oh;
  logic [BLK_Y_NUM-1:0] w_y_oh;
  logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0] w_excl;

  assign w_offer = (r_state == BLK_SCHED_OFFER);
  assign w_hs    = w_offer && CompBlkRdy;
  assign w_x_oh  = BLK_X_NUM'(1) << r_x_idx;
  assign w_y_oh  = BLK_Y_NUM'(1) << r_y_idx;

  // On handshake the search continues from the block being granted, so the
  // follow-on offer is already fair without waiting for the pointer update.
  assign w_sp_x = w_hs ? r_x_idx : r_ptr_x;
  assign w_sp_y = w_hs ? r_y_idx : r_ptr_y;

  // The held block is hidden from the search: its BlkIsEnough bit is only
  // cleared on the CompBlkEn edge, so it must not be re-offered on stale data.
  always_comb begin
    w_excl = '0;
    for (int unsigned y = 0; y < BLK_Y_NUM; y++) begin
      for (int unsigned x = 0; x < BLK_X_NUM; x++) begin
        w_excl[y][x] = w_offer & w_y_oh[y] & w_x_oh[x];
      end
    end
  end

  img_rsz_rr_pick_2d #(
    .X_NUM (BLK_X_NUM),
    .Y_NUM (BLK_Y_NUM)
  ) u_pick (
    .i_req   (BlkIsEnough),
    .i_excl  (w_excl),
    .i_ptr_x (w_sp_x),
    .i_ptr_y (w_sp_y),
    .o_found (w_found),
    .o_x_idx (w_pick_x),
    .o_y_idx (w_pick_y)
  );

  // Flush restores the full budget before this cycle's handshake/done apply;
  // a Done with no credit outstanding is dropped.
  always_comb begin
    w_cred_base = FrameFlush ? C_MAX : r_cred;
    w_cred_nxt  = w_cred_base;
    if (w_hs && !CompBlkDone) begin
      w_cred_nxt = w_cred_base - CW'(1);
    end else if (!w_hs && CompBlkDone && (w_cred_base != C_MAX)) begin
      w_cred_nxt = w_cred_base + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      BLK_SCHED_IDLE: begin
        if (w_found && (w_cred_nxt != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = BLK_SCHED_OFFER;
        end
      end
      BLK_SCHED_OFFER: begin
        if (w_hs) begin
          if (w_found && (w_cred_nxt != '0)) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = BLK_SCHED_IDLE;
          end
        end
      end
      default: w_state_nxt = BLK_SCHED_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= BLK_SCHED_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x_idx <= '0;
      r_y_idx <= '0;
      r_ptr_x <= XW'(BLK_X_NUM - 1);
      r_ptr_y <= YW'(BLK_Y_NUM - 1);
      r_cred  <= C_MAX;
    end else begin
      if (w_load) begin
        r_x_idx <= w_pick_x;
        r_y_idx <= w_pick_y;
      end
      if (FrameFlush) begin
        r_ptr_x <= XW'(BLK_X_NUM - 1);
        r_ptr_y <= YW'(BLK_Y_NUM - 1);
      end else if (w_hs) begin
        r_ptr_x <= r_x_idx;
        r_ptr_y <= r_y_idx;
      end
      r_cred <= w_cred_nxt;
    end
  end

  // Compute returning more blocks than it was given points to a protocol bug.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      assert (!(CompBlkDone && !w_hs && !FrameFlush && (r_cred == C_MAX)));
    end
  end

  assign CompBlkVld  = w_offer;
  assign CompBlkXIdx = r_x_idx;
  assign CompBlkYIdx = r_y_idx;
  assign CompBlkEn   = w_hs;
  assign CompBlkXMsk = w_hs ? w_x_oh : '0;
  assign CompBlkYMsk = w_hs ? w_y_oh : '0;

endmodule

// File: tb/tb_img_rsz_blk_sched.sv
// Self-checking bench for img_rsz_blk_sched on a 4x4 grid with 2 credits.
module tb_img_rsz_blk_sched;

  localparam int XN   = 4;
  localparam int YN   = 4;
  localparam int N    = XN * YN;
  localparam int MAXC = 2;

  logic                   Clk = 1'b0;
  logic                   Reset;
  logic [YN-1:0][XN-1:0]  BlkIsEnough;
  logic                   FrameFlush;
  logic [XN-1:0]          CompBlkXMsk;
  logic [YN-1:0]          CompBlkYMsk;
  logic                   CompBlkEn;
  logic [1:0]             CompBlkXIdx;
  logic [1:0]             CompBlkYIdx;
  logic                   CompBlkVld;
  logic                   CompBlkRdy;
  logic                   CompBlkDone;

  img_rsz_blk_sched #(
    .BLK_X_NUM       (XN),
    .BLK_Y_NUM       (YN),
    .MAX_OUTSTANDING (MAXC)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .BlkIsEnough (BlkIsEnough),
    .FrameFlush  (FrameFlush),
    .CompBlkXMsk (CompBlkXMsk),
    .CompBlkYMsk (CompBlkYMsk),
    .CompBlkEn   (CompBlkEn),
    .CompBlkXIdx (CompBlkXIdx),
    .CompBlkYIdx (CompBlkYIdx),
    .CompBlkVld  (CompBlkVld),
    .CompBlkRdy  (CompBlkRdy),
    .CompBlkDone (CompBlkDone)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Block buffer image and behavioural scheduler model.
  bit map [N];
  bit m_off;     // an offer is outstanding
  int m_held;    // raster index of the offered block
  int m_ptr;     // raster index of the last grant
  int m_cred;
  int grants[$]; // raster indices granted, in order
  bit s_vld;     // CompBlkVld as last sampled

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic gchk(input string nm, input int k, input int v);
    if (k < grants.size()) check(nm, grants[k], v);
    else check(nm, -1, v);
  endtask

  task automatic model_reset();
    m_off  = 1'b0;
    m_held = 0;
    m_ptr  = N - 1;
    m_cred = MAXC;
  endtask

  // First requesting block strictly after sp in raster order, wrapping.
  function automatic int find(input int sp, input bit use_ex, input int ex);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (sp + k) % N;
      if (map[i] && !(use_ex && i == ex)) return i;
    end
    return -1;
  endfunction

  task automatic cycle(input bit rdy, input bit done, input bit flush);
    bit hs;
    int cn, cand, prev;
    @(negedge Clk);
    for (int i = 0; i < N; i++) BlkIsEnough[i / XN][i % XN] = map[i];
    CompBlkRdy  = rdy;
    CompBlkDone = done;
    FrameFlush  = flush;
    #1;
    hs    = m_off && rdy;
    s_vld = CompBlkVld;
    check("vld", int'(CompBlkVld), int'(m_off));
    check("en", int'(CompBlkEn), int'(hs));
    if (m_off) begin
      check("xidx", int'(CompBlkXIdx), m_held % XN);
      check("yidx", int'(CompBlkYIdx), m_held / XN);
    end
    check("xmsk", int'(CompBlkXMsk), hs ? (1 << (m_held % XN)) : 0);
    check("ymsk", int'(CompBlkYMsk), hs ? (1 << (m_held / XN)) : 0);

    cn = (flush ? MAXC : m_cred) - int'(hs) + int'(done);
    if (cn > MAXC) cn = MAXC;
    cand = find(hs ? m_held : m_ptr, m_off, m_held);
    prev = m_held;
    if (hs) begin
      grants.push_back(prev);
      map[prev] = 1'b0;
    end
    if (!m_off || hs) begin
      if (cand >= 0 && cn > 0) begin
        m_off  = 1'b1;
        m_held = cand;
      end else begin
        m_off = 1'b0;
      end
    end
    if (flush) m_ptr = N - 1;
    else if (hs) m_ptr = prev;
    m_cred = cn;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    Reset       = 1'b1;
    CompBlkRdy  = 1'b1;
    CompBlkDone = 1'b0;
    FrameFlush  = 1'b0;
    #1;
    check("rst_vld", int'(CompBlkVld), 0);
    check("rst_en", int'(CompBlkEn), 0);
    check("rst_xidx", int'(CompBlkXIdx), 0);
    check("rst_yidx", int'(CompBlkYIdx), 0);
    check("rst_xmsk", int'(CompBlkXMsk), 0);
    check("rst_ymsk", int'(CompBlkYMsk), 0);
    for (int i = 0; i < N; i++) map[i] = 1'b0;
    BlkIsEnough = '0;
    model_reset();
    grants.delete();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset       = 1'b1;
    BlkIsEnough = '0;
    FrameFlush  = 1'b0;
    CompBlkRdy  = 1'b0;
    CompBlkDone = 1'b0;
    model_reset();

    // Round-robin order: (0,0),(0,3),(2,1) -> raster 0,3,9.
    do_reset();
    map[0] = 1; map[3] = 1; map[9] = 1;
    cycle(1, 0, 0);
    check("rr_lat0", int'(s_vld), 0);
    cycle(1, m_cred < MAXC, 0);
    check("rr_lat1", int'(s_vld), 1);
    repeat (5) cycle(1, m_cred < MAXC, 0);
    check("rr_cnt", grants.size(), 3);
    gchk("rr_g0", 0, 0);
    gchk("rr_g1", 1, 3);
    gchk("rr_g2", 2, 9);

    // Starvation: (0,0) keeps coming back, (3,3) still gets its turn.
    do_reset();
    map[15] = 1;
    repeat (4) begin
      map[0] = 1;
      cycle(1, m_cred < MAXC, 0);
    end
    repeat (4) cycle(1, m_cred < MAXC, 0);
    gchk("st_g0", 0, 0);
    gchk("st_g1", 1, 15);
    gchk("st_g2", 2, 0);

    // Backpressure: (1,2) held for 10 cycles, then (0,1) follows.
    do_reset();
    map[6] = 1;
    cycle(0, 0, 0);
    map[1] = 1;
    repeat (10) cycle(0, 0, 0);
    check("bp_vld", int'(s_vld), 1);
    check("bp_xidx", int'(CompBlkXIdx), 2);
    check("bp_yidx", int'(CompBlkYIdx), 1);
    check("bp_nogrant", grants.size(), 0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    gchk("bp_g0", 0, 6);
    gchk("bp_g1", 1, 1);

    // Credits: only two go out without Done.
    do_reset();
    map[2] = 1; map[5] = 1; map[7] = 1;
    repeat (6) cycle(1, 0, 0);
    check("cr_cnt", grants.size(), 2);
    check("cr_stall", int'(s_vld), 0);
    cycle(1, 1, 0);
    check("cr_done_cyc", int'(s_vld), 0);
    map[10] = 1;
    cycle(1, 1, 0);
    check("cr_third", int'(s_vld), 1);
    cycle(1, 0, 0);
    check("cr_hsdone", int'(s_vld), 1);
    cycle(1, 0, 0);
    check("cr_empty", int'(s_vld), 0);
    gchk("cr_g2", 2, 7);
    gchk("cr_g3", 3, 10);

    // FrameFlush: pointer at (2,2), next grant restarts at (1,0).
    do_reset();
    map[10] = 1;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    map[4] = 1; map[12] = 1;
    repeat (4) cycle(1, 0, 0);
    gchk("fl_g0", 0, 10);
    gchk("fl_g1", 1, 4);
    gchk("fl_g2", 2, 12);

    // Async reset during an offer; search restarts at (0,0) afterwards.
    do_reset();
    map[5] = 1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("ar_pre", int'(s_vld), 1);
    do_reset();
    map[5] = 1; map[2] = 1;
    repeat (3) cycle(1, m_cred < MAXC, 0);
    gchk("ar_g0", 0, 2);
    gchk("ar_g1", 1, 5);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit rdy, done, flush;
      int dens;
      dens = (c < 2000) ? 3 : 1;
      if ($urandom_range(0, dens) == 0) map[$urandom_range(0, N - 1)] = 1;
      if ($urandom_range(0, 24) == 0) map[$urandom_range(0, N - 1)] = 0;
      rdy   = ($urandom_range(0, 2) != 0);
      done  = (m_cred < MAXC) && ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 59) == 0);
      cycle(rdy, done, flush);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
